counterup16_4ch_tc_async_resetn: RTL and testbench

Four 16-bit up counters on a single clock. Each counter has its own enable, synchronous clear, parallel load and programmable terminal count (TC). It produces a registered TC pulse and a sticky wrap flag, and all four counts can be snapshotted atomically. This block is the up-counting, event-generating counterpart to the team's down-counter blocks and serves as a timer/tick source for the simple_registers benchmarks.

---
 rtl/counterup16_4ch_tc_async_resetn.sv | 113 +++++++++++
 tb/tb_counterup16_4ch_tc_async_resetn.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/counterup16_4ch_tc_async_resetn.sv
// Four independent up counters with programmable terminal count, registered
// wrap pulse, sticky wrap flag and an atomic snapshot of all four counts.
module counterup16_4ch_tc_async_resetn #(
  parameter int               WIDTH  = 16,
  parameter logic [WIDTH-1:0] TC_RST = {WIDTH{1'b1}}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       en,
  input  logic [3:0]       clr,
  input  logic [3:0]       load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             tc_we,
  input  logic [1:0]       tc_sel,
  input  logic [WIDTH-1:0] tc_data,
  input  logic [3:0]       wrap_clr,
  input  logic             snap,
  output logic [WIDTH-1:0] cnt0_16,
  output logic [WIDTH-1:0] cnt1_16,
  output logic [WIDTH-1:0] cnt2_16,
  output logic [WIDTH-1:0] cnt3_16,
  output logic [3:0]       tc_hit,
  output logic [3:0]       wrap_flag,
  output logic [WIDTH-1:0] snap0,
  output logic [WIDTH-1:0] snap1,
  output logic [WIDTH-1:0] snap2,
  output logic [WIDTH-1:0] snap3,
  output logic             snap_valid
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt      [4];
  logic [WIDTH-1:0] cnt_next [4];
  logic [WIDTH-1:0] tc       [4];
  logic [WIDTH-1:0] snap_reg [4];
  logic [3:0]       wrap_ev;

  // A wrap happens either at the programmed TC or on natural overflow, so a
  // counter loaded above its TC runs to all-ones before returning to 0.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_next[i] = cnt[i];
      wrap_ev[i]  = 1'b0;
      if (clr[i]) begin
        cnt_next[i] = '0;
      end else if (load[i]) begin
        cnt_next[i] = load_val;
      end else if (en[i]) begin
        if ((cnt[i] == tc[i]) || (cnt[i] == ALL_ONES)) begin
          cnt_next[i] = '0;
          wrap_ev[i]  = 1'b1;
        end else begin
          cnt_next[i] = cnt[i] + ONE;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
      tc_hit    <= '0;
      wrap_flag <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= cnt_next[i];
      end
      tc_hit    <= wrap_ev;
      wrap_flag <= wrap_ev | (wrap_flag & ~wrap_clr);
    end
  end

  // The comparison above reads the old TC, so a write takes effect next edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        tc[i] <= TC_RST;
      end
    end else if (tc_we) begin
      tc[tc_sel] <= tc_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        snap_reg[i] <= '0;
      end
      snap_valid <= 1'b0;
    end else begin
      if (snap) begin
        for (int i = 0; i < 4; i++) begin
          snap_reg[i] <= cnt[i];
        end
      end
      snap_valid <= snap;
    end
  end

  assign cnt0_16 = cnt[0];
  assign cnt1_16 = cnt[1];
  assign cnt2_16 = cnt[2];
  assign cnt3_16 = cnt[3];
  assign snap0   = snap_reg[0];
  assign snap1   = snap_reg[1];
  assign snap2   = snap_reg[2];
  assign snap3   = snap_reg[3];

endmodule

// File: tb/tb_counterup16_4ch_tc_async_resetn.sv
// Randomized bench for the four-channel up counter, checked every cycle
// against an arithmetic reference model of the counters, TCs and snapshots.
module tb_counterup16_4ch_tc_async_resetn;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  en, clr, load, wrap_clr;
  logic [15:0] load_val, tc_data;
  logic        tc_we, snap;
  logic [1:0]  tc_sel;
  logic [15:0] cnt0_16, cnt1_16, cnt2_16, cnt3_16;
  logic [15:0] snap0, snap1, snap2, snap3;
  logic [3:0]  tc_hit, wrap_flag;
  logic        snap_valid;

  int m_cnt [4];
  int m_tc  [4];
  int m_snap[4];
  bit m_hit [4];
  bit m_flag[4];
  bit m_sv;

  int compare_count  = 0;
  int mismatch_count = 0;

  counterup16_4ch_tc_async_resetn dut (
    .clock(clock), .reset(reset), .en(en), .clr(clr), .load(load),
    .load_val(load_val), .tc_we(tc_we), .tc_sel(tc_sel), .tc_data(tc_data),
    .wrap_clr(wrap_clr), .snap(snap),
    .cnt0_16(cnt0_16), .cnt1_16(cnt1_16), .cnt2_16(cnt2_16), .cnt3_16(cnt3_16),
    .tc_hit(tc_hit), .wrap_flag(wrap_flag),
    .snap0(snap0), .snap1(snap1), .snap2(snap2), .snap3(snap3),
    .snap_valid(snap_valid)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i]  = 0;
      m_tc[i]   = 65535;
      m_snap[i] = 0;
      m_hit[i]  = 0;
      m_flag[i] = 0;
    end
    m_sv = 0;
  endtask

  // One clock edge of the reference: counts wrap at TC or on passing 65535.
  task automatic modelClock();
    int pre[4];
    int nxt;
    for (int i = 0; i < 4; i++) pre[i] = m_cnt[i];
    for (int i = 0; i < 4; i++) begin
      m_hit[i] = 0;
      if (clr[i]) m_cnt[i] = 0;
      else if (load[i]) m_cnt[i] = int'(load_val);
      else if (en[i]) begin
        nxt = (m_cnt[i] + 1) % 65536;
        if (m_cnt[i] == m_tc[i] || nxt == 0) begin
          m_cnt[i] = 0;
          m_hit[i] = 1;
        end else begin
          m_cnt[i] = nxt;
        end
      end
      m_flag[i] = m_hit[i] || (m_flag[i] && !wrap_clr[i]);
    end
    if (tc_we) m_tc[tc_sel] = int'(tc_data);
    if (snap) for (int i = 0; i < 4; i++) m_snap[i] = pre[i];
    m_sv = snap;
  endtask

  task automatic checkAll(input string tag);
    logic [3:0] exp_hit, exp_flag;
    for (int i = 0; i < 4; i++) begin
      exp_hit[i]  = m_hit[i];
      exp_flag[i] = m_flag[i];
    end
    checkOutput({tag, ".cnt0"}, 32'(cnt0_16), 32'(m_cnt[0]));
    checkOutput({tag, ".cnt1"}, 32'(cnt1_16), 32'(m_cnt[1]));
    checkOutput({tag, ".cnt2"}, 32'(cnt2_16), 32'(m_cnt[2]));
    checkOutput({tag, ".cnt3"}, 32'(cnt3_16), 32'(m_cnt[3]));
    checkOutput({tag, ".tc_hit"}, 32'(tc_hit), 32'(exp_hit));
    checkOutput({tag, ".wrap_flag"}, 32'(wrap_flag), 32'(exp_flag));
    checkOutput({tag, ".snap0"}, 32'(snap0), 32'(m_snap[0]));
    checkOutput({tag, ".snap1"}, 32'(snap1), 32'(m_snap[1]));
    checkOutput({tag, ".snap2"}, 32'(snap2), 32'(m_snap[2]));
    checkOutput({tag, ".snap3"}, 32'(snap3), 32'(m_snap[3]));
    checkOutput({tag, ".snap_valid"}, 32'(snap_valid), 32'(m_sv));
  endtask

  // Drives one cycle of inputs just after a falling edge and checks the
  // result on the next falling edge.
  task automatic applyStimulus(input string tag, input logic [3:0] e, input logic [3:0] c,
                               input logic [3:0] l, input logic [3:0] wc,
                               input logic [15:0] lv, input logic twe,
                               input logic [1:0] ts, input logic [15:0] td,
                               input logic sn);
    en = e; clr = c; load = l; wrap_clr = wc; load_val = lv;
    tc_we = twe; tc_sel = ts; tc_data = td; snap = sn;
    @(posedge clock);
    modelClock();
    @(negedge clock);
    checkAll(tag);
  endtask

  initial begin
    logic [3:0]  r_en, r_clr, r_load, r_wc;
    logic [15:0] r_lv, r_td;
    logic        r_twe, r_snap;
    logic [1:0]  r_ts;

    reset = 1'b0;
    en = '0; clr = '0; load = '0; wrap_clr = '0; load_val = '0;
    tc_we = 1'b0; tc_sel = '0; tc_data = '0; snap = 1'b0;
    #12;
    modelReset();
    checkAll("reset");
    @(negedge clock);
    reset = 1'b1;

    for (int k = 0; k < 5; k++)
      applyStimulus("en_all", 4'hF, 4'h0, 4'h0, 4'h0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b0);
    checkOutput("en_all.cnt3_is_5", 32'(cnt3_16), 32'd5);

    applyStimulus("tc2_wr", 4'h0, 4'h4, 4'h0, 4'h0, 16'h0, 1'b1, 2'd2, 16'd3, 1'b0);
    for (int k = 0; k < 4; k++)
      applyStimulus("tc2_run", 4'h4, 4'h0, 4'h0, 4'h0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b0);
    checkOutput("tc2.wrap_hit", 32'(tc_hit[2]), 32'd1);
    applyStimulus("tc2_wclr", 4'h4, 4'h0, 4'h0, 4'h4, 16'h0, 1'b0, 2'd0, 16'h0, 1'b0);
    applyStimulus("tc2_run", 4'h4, 4'h0, 4'h0, 4'h0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b0);
    applyStimulus("tc2_run", 4'h4, 4'h0, 4'h0, 4'h0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b0);
    applyStimulus("tc2_setwin", 4'h4, 4'h0, 4'h0, 4'h4, 16'h0, 1'b0, 2'd0, 16'h0, 1'b0);
    checkOutput("tc2.set_wins", 32'(wrap_flag[2]), 32'd1);

    applyStimulus("ld1", 4'h0, 4'h0, 4'h2, 4'h0, 16'hFFFE, 1'b1, 2'd1, 16'h0010, 1'b0);
    for (int k = 0; k < 19; k++)
      applyStimulus("ld1_run", 4'h2, 4'h0, 4'h0, 4'h0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b0);
    checkOutput("ld1.second_hit", 32'(tc_hit[1]), 32'd1);

    applyStimulus("prio0", 4'h1, 4'h1, 4'h1, 4'h0, 16'h1234, 1'b0, 2'd0, 16'h0, 1'b0);
    applyStimulus("prio0b", 4'h1, 4'h0, 4'h1, 4'h0, 16'h1234, 1'b0, 2'd0, 16'h0, 1'b0);
    checkOutput("prio0.loaded", 32'(cnt0_16), 32'h1234);

    applyStimulus("snap_ld", 4'h0, 4'h0, 4'h8, 4'h0, 16'h00A0, 1'b0, 2'd0, 16'h0, 1'b0);
    applyStimulus("snap_go", 4'h8, 4'h0, 4'h0, 4'h0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b1);
    checkOutput("snap.pre_edge", 32'(snap3), 32'h00A0);
    applyStimulus("snap_after", 4'h8, 4'h0, 4'h0, 4'h0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b0);

    applyStimulus("ar_ld", 4'h0, 4'h0, 4'h1, 4'h0, 16'h0042, 1'b1, 2'd0, 16'h0005, 1'b0);
    en = 4'h1; load = 4'h0; tc_we = 1'b0;
    #1 reset = 1'b0;
    #1 modelReset();
    checkAll("async_rst");
    #1 reset = 1'b1;
    for (int k = 0; k < 3; k++)
      applyStimulus("ar_resume", 4'h1, 4'h0, 4'h0, 4'h0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      r_en   = 4'($urandom) | 4'($urandom);
      r_clr  = 4'($urandom & $urandom & $urandom & $urandom);
      r_load = 4'($urandom & $urandom & $urandom);
      r_wc   = 4'($urandom & $urandom);
      case ($urandom_range(0, 3))
        0:       r_lv = 16'hFFFF - 16'($urandom_range(0, 6));
        1:       r_lv = 16'($urandom);
        default: r_lv = 16'($urandom_range(0, 30));
      endcase
      r_twe  = ($urandom_range(0, 7) == 0);
      r_ts   = 2'($urandom);
      r_td   = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 40));
      r_snap = ($urandom_range(0, 3) == 0);
      applyStimulus("rand", r_en, r_clr, r_load, r_wc, r_lv, r_twe, r_ts, r_td, r_snap);
      if (n % 700 == 350) begin
        #2 reset = 1'b0;
        #1 modelReset();
        checkAll("rand_rst");
        @(negedge clock);
        reset = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
